booth_mul_seq: RTL

//  Multi-cycle radix-2 Booth multiplier, parametrised in operand width, with
//  per-transaction signed/unsigned mode. Full 2*WIDTH-bit product split into high/low words.

---
 rtl/booth_mul_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: WIDTH+1 Booth steps over (WIDTH+1)-bit
// extended operands, full 2*WIDTH-bit product, valid/ready in and out, abort.
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z_lo,
  output logic [WIDTH-1:0] z_hi,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; out_valid stays high with stable data until out_ready is seen.

  localparam int AW = 2 * WIDTH + 3;
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] zlo_q, zlo_d, zhi_q, zhi_d;

  logic [WIDTH:0]   x_ext, y_ext, a_cur, a_new;
  logic [AW-1:0]    acc_step;

  assign x_ext = {is_signed & x[WIDTH-1], x};
  assign y_ext = {is_signed & y[WIDTH-1], y};
  assign a_cur = acc_q[AW-1:WIDTH+2];

  // acc_q = {A, Q, q_-1}; one Booth step then arithmetic shift right by one.
  always_comb begin
    a_new = a_cur;
    case (acc_q[1:0])
      2'b10:   a_new = a_cur - m_q;
      2'b01:   a_new = a_cur + m_q;
      default: a_new = a_cur;
    endcase
    acc_step = {a_new[WIDTH], a_new, acc_q[WIDTH+1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    acc_d   = acc_q;
    zlo_d   = zlo_q;
    zhi_d   = zhi_q;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      m_d     = '0;
      acc_d   = '0;
      zlo_d   = '0;
      zhi_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_d = S_RUN;
            cnt_d   = '0;
            m_d     = y_ext;
            acc_d   = {{(WIDTH+1){1'b0}}, x_ext, 1'b0};
          end
        end
        S_RUN: begin
          // Counts 0..WIDTH are Booth steps; the extra count publishes the product.
          if (cnt_q == LAST) begin
            state_d = S_DONE;
            zlo_d   = acc_q[WIDTH:1];
            zhi_d   = acc_q[2*WIDTH:WIDTH+1];
          end else begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      zlo_q   <= '0;
      zhi_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      zlo_q   <= zlo_d;
      zhi_q   <= zhi_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && rst_n;
  assign out_valid = (state_q == S_DONE);
  assign z_lo      = zlo_q;
  assign z_hi      = zhi_q;
  assign dbg_state = state_q;

endmodule
